// File: rtl/apb2axi_pkg.sv
// Shared types and sizing for the apb2axi gateway and its host-side APB initiator.
package apb2axi_pkg;

  localparam int unsigned APB_ADDR_W          = 32;
  localparam int unsigned APB_DATA_W          = 32;
  localparam int unsigned APB_MST_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_mst_req_t;

endpackage

// File: rtl/apb2axi_apb_master.sv
// APB3 initiator: one valid/ready request becomes one APB transfer; the result comes back on a
// valid/ready response stream. A watchdog aborts ACCESS phases that never see pready.
module apb2axi_apb_master
  import apb2axi_pkg::*;
#(
  parameter int unsigned APB_ADDR_W     = apb2axi_pkg::APB_ADDR_W,
  parameter int unsigned APB_DATA_W     = apb2axi_pkg::APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = APB_MST_TIMEOUT_DEF
) (
  input  logic                  pclk,
  input  logic                  preset,
  // request stream
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  // APB3 initiator port
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [APB_DATA_W-1:0] prdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_mst_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
    end
  end

  // Every output is registered, so each branch computes the values seen in the *next* state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        // req_ready_q gates acceptance so nothing is taken on the first edge after reset.
        if (req_valid && req_ready_q) begin
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready) begin
          rsp_write_d   = pwrite_q;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_write_d   = pwrite_q;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb2axi_apb_master.sv
// Randomized scoreboard bench for apb2axi_apb_master: a driver issues requests, a slave model
// answers with chosen wait states, and a monitor checks each response against the model.
module tb_apb2axi_apb_master;
  import apb2axi_pkg::*;

  localparam int unsigned TO = 16;
  localparam int unsigned AW = APB_ADDR_W;
  localparam int unsigned DW = APB_DATA_W;

  typedef struct {
    bit                write;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    int unsigned       wait_n;  // pready-low ACCESS cycles before the slave answers
    bit                err;
    int unsigned       hold;    // cycles the monitor withholds rsp_ready
    longint            acc_cyc;
  } item_t;

  logic          pclk = 1'b0;
  logic          preset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  longint last_acc;
  item_t  sb_q[$];
  item_t  cfg_q[$];

  apb2axi_apb_master #(
    .APB_ADDR_W    (AW),
    .APB_DATA_W    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] got,
                              input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Reference rules: a slave silent for TO ACCESS cycles is aborted; otherwise it answers on
  // ACCESS cycle wait_n+1.
  function automatic int unsigned exp_len(input item_t it);
    return (it.wait_n >= TO) ? TO : it.wait_n + 1;
  endfunction

  function automatic logic [DW+2:0] exp_rsp(input item_t it);
    if (it.wait_n >= TO) return {it.write, 1'b1, 1'b1, DW'(0)};
    return {it.write, it.err, 1'b0, (it.write ? DW'(0) : it.rdata)};
  endfunction

  function automatic item_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input int unsigned wt, input bit e, input logic [DW-1:0] rd,
                               input int unsigned h);
    item_t it;
    it.write = w; it.addr = a; it.wdata = wd; it.wait_n = wt;
    it.err = e; it.rdata = rd; it.hold = h; it.acc_cyc = 0;
    return it;
  endfunction

  // Called and returns at a negedge.
  task automatic issue(input item_t it, input bit chk_int);
    int n = 0;
    req_valid = 1'b1; req_write = it.write; req_addr = it.addr; req_wdata = it.wdata;
    while (!req_ready && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 1, 0);
      req_valid = 1'b0;
      return;
    end
    it.acc_cyc = cyc;
    if (chk_int && last_acc >= 0) chk("issue_interval", cyc - last_acc, 4);
    last_acc = cyc;
    sb_q.push_back(it);
    cfg_q.push_back(it);
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    chk("drain_scoreboard_empty", sb_q.size(), 0);
  endtask

  // Slave model: holds pready low for wait_n ACCESS cycles, randomizes pins it must ignore.
  initial begin : slave
    item_t       s;
    int unsigned acc;
    bit          in_acc;
    acc = 0; in_acc = 0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    s = mk(1'b0, '0, '0, 0, 1'b0, '0, 0);
    forever begin
      @(negedge pclk);
      if (preset) begin
        acc = 0; in_acc = 0;
      end else begin
        if (in_acc && !(psel && penable)) begin
          chk("access_len", acc, exp_len(s));
          in_acc = 0;
        end
        if (psel && !penable) begin
          if (cfg_q.size() == 0) chk("setup_without_request", 1, 0);
          else s = cfg_q.pop_front();
          acc = 0;
          chk("setup_bus", {pwrite, paddr, pwdata}, {s.write, s.addr, s.wdata});
          pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        end else if (psel && penable) begin
          in_acc = 1;
          chk("access_bus_stable", {pwrite, paddr, pwdata}, {s.write, s.addr, s.wdata});
          pready  = (acc == s.wait_n);
          pslverr = pready ? s.err : 1'($urandom);
          prdata  = pready ? s.rdata : $urandom;
          acc++;
        end else begin
          pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new response, then checks it stays frozen.
  initial begin : monitor
    item_t         cur;
    bit            active;
    int unsigned   held;
    logic [DW+2:0] snap;
    active = 0; held = 0; rsp_ready = 1'b0; snap = '0;
    cur = mk(1'b0, '0, '0, 0, 1'b0, '0, 0);
    forever begin
      @(negedge pclk);
      if (preset || !rsp_valid) begin
        active = 0; rsp_ready = 1'b0;
      end else begin
        chk("resp_phase_bus_idle", {req_ready, psel, penable}, 3'b000);
        if (!active) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
            rsp_ready = 1'b1;
          end else begin
            cur = sb_q.pop_front();
            active = 1; held = 0;
            chk("rsp_fields", {rsp_write, rsp_slverr, rsp_timeout, rsp_rdata}, exp_rsp(cur));
            chk("rsp_latency", cyc - cur.acc_cyc, longint'(2 + exp_len(cur)));
            snap = {rsp_write, rsp_slverr, rsp_timeout, rsp_rdata};
          end
        end else begin
          chk("rsp_stable", {rsp_write, rsp_slverr, rsp_timeout, rsp_rdata}, snap);
        end
        if (active && held >= cur.hold) rsp_ready = 1'b1;
        held++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int unsigned wt;
    bit          seen;
    int          n;
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    last_acc = -1;
    #1;
    chk("reset_rsp_outputs", {req_ready, rsp_valid, rsp_write, rsp_slverr, rsp_timeout,
                              rsp_rdata}, 0);
    chk("reset_apb_outputs", {psel, penable, pwrite, paddr, pwdata}, 0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    chk("req_ready_low_after_release", req_ready, 0);
    @(posedge pclk); #1;
    chk("req_ready_first_edge", req_ready, 1);
    @(negedge pclk);

    // Directed: zero-wait write, wait-state read, timeout, recovery, threshold, slverr+hold
    issue(mk(1'b1, AW'('h08), DW'('h103), 0, 1'b0, $urandom, 0), 1'b0);
    issue(mk(1'b0, AW'('h10), $urandom, 5, 1'b0, DW'('hDEAD_BEEF), 0), 1'b0);
    issue(mk(1'b0, AW'('h20), $urandom, 1000, 1'b0, $urandom, 0), 1'b0);
    issue(mk(1'b0, AW'('h0C), $urandom, 0, 1'b0, $urandom, 0), 1'b0);
    issue(mk(1'b0, AW'('h24), $urandom, TO - 1, 1'b0, $urandom, 0), 1'b0);
    issue(mk(1'b0, AW'('h28), $urandom, TO, 1'b0, $urandom, 0), 1'b0);
    issue(mk(1'b1, AW'('h14), $urandom, 0, 1'b1, $urandom, 10), 1'b0);
    drain();

    // Gateway programming sequence, back to back
    last_acc = -1;
    issue(mk(1'b1, AW'('h04), DW'('h0), 0, 1'b0, $urandom, 0), 1'b1);
    issue(mk(1'b1, AW'('h08), DW'('h8000_0003), 0, 1'b0, $urandom, 0), 1'b1);
    issue(mk(1'b1, AW'('h00), DW'('h1000), 0, 1'b0, $urandom, 0), 1'b1);
    issue(mk(1'b0, AW'('h0C), $urandom, 0, 1'b0, $urandom, 0), 1'b1);
    drain();

    for (int i = 0; i < 200; i++) begin
      wt = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(negedge pclk);
      issue(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63) << 2), $urandom, wt,
               1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3)), 1'b0);
    end
    drain();

    // Reset in the middle of a stalled read
    issue(mk(1'b0, AW'('h18), $urandom, 1000, 1'b0, $urandom, 0), 1'b0);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("rst_test_in_access", {psel, penable}, 2'b11);
    repeat (3) @(negedge pclk);
    @(posedge pclk); #2;
    preset = 1'b1;
    #1;
    chk("rst_async_psel_penable", {psel, penable}, 2'b00);
    sb_q.delete();
    cfg_q.delete();
    @(negedge pclk);
    preset = 1'b0;
    chk("rst_mid_req_ready_low", req_ready, 0);
    @(posedge pclk); #1;
    chk("rst_mid_req_ready_edge", req_ready, 1);
    seen = 0;
    repeat (30) begin
      @(negedge pclk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_rst", seen, 0);
    issue(mk(1'b0, AW'('h0C), $urandom, 2, 1'b0, $urandom, 1), 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
